// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns M-stage loads and stores into single-beat bus
// accesses, stalls the pipeline while waiting, and returns extended load data.
module lsu_mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       data_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lo_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [31:0]       mem_addr_reg;
  logic [3:0]        mem_be_reg;
  logic [31:0]       mem_wdata_reg;
  logic              bus_err_reg;

  logic        is_word;
  logic        is_half;
  logic        access;
  logic        misalign;
  logic        start;
  logic [3:0]  byte_lane;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  // Funct3 bit 1 set means word (covers the 011/110/111 encodings too)
  assign is_word  = Funct3M[1];
  assign is_half  = ~Funct3M[1] & Funct3M[0];
  assign access   = reset & (state_reg == IDLE) & (MemReadM | MemWriteM);
  assign misalign = (is_half & ALUResult_M[0]) | (is_word & (|ALUResult_M[1:0]));
  assign start    = access & ~misalign;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = (ALUResult_M[1:0] == 2'(gi));
      assign wdata_next[8*gi +: 8] = is_word ? WriteDataM[8*gi +: 8] :
                                     is_half ? WriteDataM[8*(gi%2) +: 8] :
                                               WriteDataM[7:0];
    end
  endgenerate

  always_comb begin
    be_next = 4'hF;
    if (MemWriteM && !is_word)
      be_next = is_half ? (ALUResult_M[1] ? 4'b1100 : 4'b0011) : byte_lane;
  end

  // Word loads are always aligned, so the shifted word equals the raw word there
  always_comb begin
    rdata_shift = mem_rdata >> {addr_lo_reg, 3'b000};
    if (funct3_reg[1])
      load_ext = rdata_shift;
    else if (funct3_reg[0])
      load_ext = funct3_reg[2] ? {16'h0000, rdata_shift[15:0]}
                               : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
    else
      load_ext = funct3_reg[2] ? {24'h000000, rdata_shift[7:0]}
                               : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      data_reg      <= '0;
      funct3_reg    <= '0;
      addr_lo_reg   <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          bus_err_reg <= 1'b0;
          if (start) begin
            state_reg     <= BUSY;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= MemWriteM;
            mem_addr_reg  <= {ALUResult_M[31:2], 2'b00};
            mem_be_reg    <= be_next;
            mem_wdata_reg <= wdata_next;
            funct3_reg    <= Funct3M;
            addr_lo_reg   <= ALUResult_M[1:0];
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            data_reg    <= mem_we_reg ? 32'h0 : load_ext;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            data_reg    <= '0;
            bus_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg   <= IDLE;
          bus_err_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign StallM    = start | (state_reg == BUSY);
  assign MisalignM = access & misalign;
  assign BusErrM   = bus_err_reg;
  assign ReadData  = (state_reg == DONE) ? data_reg : 32'h0;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a table of single accesses with immediate ack,
// plus hand sequences for reset, stray ack, delayed ack, timeout and reset in BUSY.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResult_M, WriteDataM;
  logic [31:0] ReadData;
  logic        StallM, MisalignM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResult_M(ALUResult_M), .WriteDataM(WriteDataM),
    .ReadData(ReadData), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_read;
    logic        mis;
    logic        chk_read;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic drive_idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResult_M = 32'h0; WriteDataM = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
    ALUResult_M = v.addr; WriteDataM = v.wdata; mem_ack = 1'b0;
    #1;
    chk1("misalign_c0", MisalignM, v.mis);
    chk1("stall_c0", StallM, !v.mis);
    chk1("req_c0", mem_req, 1'b0);
    if (v.mis) begin
      chk("read_mis", ReadData, 32'h0);
      @(posedge clk); #1;
      drive_idle();
      #1;
      chk1("mis_req_after", mem_req, 1'b0);
      chk1("mis_pulse_end", MisalignM, 1'b0);
      chk1("mis_stall_after", StallM, 1'b0);
    end else begin
      @(posedge clk); #1;
      chk1("busy_req", mem_req, 1'b1);
      chk1("busy_stall", StallM, 1'b1);
      chk("busy_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
      chk("busy_be", {28'h0, mem_be}, {28'h0, v.be});
      chk1("busy_we", mem_we, v.wr);
      if (v.wr) chk("busy_wdata", mem_wdata, v.exp_wdata);
      mem_ack = 1'b1; mem_rdata = v.rdata;
      #1;
      chk1("ack_stall", StallM, 1'b1);
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      // request inputs still held: DONE must ignore them
      chk1("done_stall", StallM, 1'b0);
      chk1("done_req", mem_req, 1'b0);
      chk1("done_buserr", BusErrM, 1'b0);
      if (v.chk_read) chk("done_read", ReadData, v.exp_read);
      @(posedge clk); #1;
      drive_idle();
      #1;
      chk("idle_read", ReadData, 32'h0);
      chk1("idle_stall", StallM, 1'b0);
      chk1("idle_req", mem_req, 1'b0);
    end
    $display("vec %0d: f3=%03b addr=0x%08h rd=%0b wr=%0b done", idx, v.f3, v.addr, v.rd, v.wr);
  endtask

  initial begin
    //          rd    wr    f3      addr          wdata         rdata         be       exp_wdata     exp_read      mis   chk_read
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h80AA_BBCC, 4'b1111, 32'h0,        32'h0000_00BB, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80AA_BBCC, 4'b1111, 32'h0,        32'hFFFF_80AA, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80AA_BBCC, 4'b1111, 32'h0,        32'h0000_80AA, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_7FFF, 4'b1111, 32'h0,        32'h0000_7FFF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h1234_567F, 4'b1111, 32'h0,        32'h0000_007F, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h00C3_0000, 4'b1111, 32'h0,        32'hFFFF_FFC3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0208, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b110, 32'h0000_0010, 32'h0,        32'h8000_0001, 4'b1111, 32'h0,        32'h8000_0001, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b111, 32'h0000_000C, 32'h0,        32'h7FFF_FFFE, 4'b1111, 32'h0,        32'h7FFF_FFFE, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 32'h0000_0303, 32'h1234_5678, 32'h0,        4'b1000, 32'h7878_7878, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,        4'b1100, 32'h5678_5678, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'hABCD_1234, 32'h0,        4'b0011, 32'h1234_1234, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 32'h0,        4'b1111, 32'h1122_3344, 32'h0,        1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h55AA_55AA, 32'h0,        4'b1111, 32'h55AA_55AA, 32'h0,        1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 3'b000, 32'h0000_0042, 32'h0000_003C, 32'h0,        4'b0100, 32'h3C3C_3C3C, 32'h0,        1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'b010, 32'h0000_0105, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};

    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk1("rst_misalign", MisalignM, 1'b0);
    chk1("rst_buserr", BusErrM, 1'b0);
    chk1("rst_stall", StallM, 1'b0);
    chk("rst_read", ReadData, 32'h0);
    $display("reset sequence done");
    reset = 1'b1;

    // Stray ack while idle
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk1("stray_stall", StallM, 1'b0);
    chk("stray_read", ReadData, 32'h0);
    @(posedge clk); #1;
    chk1("stray_req", mem_req, 1'b0);
    chk("stray_read2", ReadData, 32'h0);
    chk1("stray_buserr", BusErrM, 1'b0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    $display("stray ack sequence done");

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // LW with ack arriving on the last allowed BUSY cycle: ack wins over timeout
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResult_M = 32'h0000_0600;
    #1;
    chk1("late_stall_c0", StallM, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("late_req", mem_req, 1'b1);
      chk1("late_stall", StallM, 1'b1);
      chk("late_addr", mem_addr, 32'h0000_0600);
    end
    @(posedge clk); #1;
    chk1("late_req_last", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("late_read", ReadData, 32'h1357_9BDF);
    chk1("late_buserr", BusErrM, 1'b0);
    chk1("late_req_done", mem_req, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    chk("late_idle_read", ReadData, 32'h0);
    $display("ack-on-last-cycle sequence done");

    // LHU with no ack: times out after TIMEOUT BUSY cycles
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b101; ALUResult_M = 32'h0000_0300;
    #1;
    chk1("to_stall_c0", StallM, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk1("to_req", mem_req, 1'b1);
      chk1("to_buserr_busy", BusErrM, 1'b0);
    end
    @(posedge clk); #1;
    chk1("to_req_done", mem_req, 1'b0);
    chk1("to_buserr", BusErrM, 1'b1);
    chk("to_read", ReadData, 32'h0);
    chk1("to_stall_done", StallM, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    chk1("to_buserr_end", BusErrM, 1'b0);
    chk1("to_req_idle", mem_req, 1'b0);
    $display("timeout sequence done");

    // LW abandoned by reset on its second BUSY cycle
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResult_M = 32'h0000_0500;
    @(posedge clk); #1;
    chk1("rb_req1", mem_req, 1'b1);
    @(posedge clk); #1;
    chk1("rb_req2", mem_req, 1'b1);
    reset = 1'b0;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    chk1("rb_req_after", mem_req, 1'b0);
    chk1("rb_stall_after", StallM, 1'b0);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rb_read_ack", ReadData, 32'h0);
    chk1("rb_stall_ack", StallM, 1'b0);
    @(posedge clk); #1;
    chk("rb_read_next", ReadData, 32'h0);
    chk1("rb_buserr", BusErrM, 1'b0);
    chk1("rb_req_next", mem_req, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    chk("rb_read_final", ReadData, 32'h0);
    $display("reset-in-busy sequence done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum number of BUSY cycles allowed while waiting for mem_ack.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 MemReadM  input  1  the M-stage instruction is a load.
REQ-005 MemWriteM  input  1  the M-stage instruction is a store.
REQ-006 Funct3M  input  3  access size and signedness: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResult_M  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, right-aligned.
REQ-009 ReadData  output  32  extended load result, consumed by the write-back register.
REQ-010 StallM  output  1  freezes the F, D, E and M stages while an access is outstanding.
REQ-011 MisalignM  output  1  one-cycle pulse: the access was misaligned and was suppressed.
REQ-012 BusErrM  output  1  one-cycle pulse: the access timed out.
REQ-013 mem_req, mem_we  output  1 each  bus request and write enable.
REQ-014 mem_addr  output  32  word-aligned address, i.e. {ALUResult_M[31:2],2'b00}.
REQ-015 mem_be  output  4  byte-lane enables.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1  bus completion; mem_rdata is valid in the same cycle.
REQ-018 mem_rdata  input  32  bus read word.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-020 In IDLE, an aligned access (MemReadM|MemWriteM) SHALL drive StallM=1 combinationally and move the FSM to BUSY at the next edge.
REQ-021 In BUSY, mem_req=1 and StallM=1; the address, be, we and wdata registered on IDLE exit SHALL be held stable until ack.
REQ-022 On BUSY with mem_ack=1, the FSM SHALL latch the extended read data and go to DONE.
- mem_req SHALL drop at that edge.
- Minimum access latency is 2 cycles from IDLE detection to DONE.
REQ-023 In DONE, StallM=0 and ReadData holds the latched value.
- MemReadM/MemWriteM SHALL be ignored, because the same instruction is still in M.
- The next state SHALL be IDLE unconditionally.
REQ-024 In IDLE with no access, ReadData SHALL be 0.
REQ-025 If MemReadM and MemWriteM are both 1, the access SHALL be treated as a store.
REQ-026 Store lanes, selected by addr[1:0]:
- SB: be = 1<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
- SH: be = 0011 or 1100, wdata = {2{WriteDataM[15:0]}}.
- SW: be = 1111.
REQ-027 Loads: mem_be=1111. The byte or halfword at addr[1:0] SHALL be selected, then sign-extended (B, H) or zero-extended (BU, HU).
REQ-028 Funct3M values 011, 110 and 111 SHALL be treated as word accesses.
REQ-029 A misaligned access (H/HU with addr[0]=1, or W with addr[1:0]!=00) detected in IDLE SHALL:
- issue no bus request;
- pulse MisalignM for that cycle;
- keep StallM=0 and ReadData=0;
- leave the FSM in IDLE.
REQ-030 A BUSY cycle counter SHALL start at 0 on entry to BUSY.
- If the count reaches TIMEOUT-1 without mem_ack, the FSM SHALL go to DONE with latched data 0 and BusErrM pulsed in the DONE cycle.
- mem_ack arriving on the timeout cycle SHALL win.
REQ-031 mem_ack received outside BUSY SHALL be ignored.

Reset
REQ-032 While reset=0 at a clock edge, the next state SHALL be:
- FSM=IDLE, counter=0, latched data=0;
- mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0;
- MisalignM=0, BusErrM=0, StallM=0.
REQ-033 Reset asserted in BUSY SHALL abandon the access; mem_req SHALL be 0 from the following cycle, and no data SHALL be returned.

Verification
REQ-034 LB at addr 0x103 with mem_rdata=0x80AA_BBCC and ack one cycle after the request -> mem_be=1111, mem_addr=0x100, StallM high 2 cycles, DONE ReadData=0xFFFF_FF80.
REQ-035 SH at addr 0x202 with WriteDataM=0x1234_5678 -> mem_we=1, mem_be=1100, mem_wdata=0x5678_5678, StallM drops in the DONE cycle after ack.
REQ-036 LW at addr 0x105 -> MisalignM pulses 1 cycle, mem_req stays 0, StallM=0, ReadData=0.
REQ-037 LHU at addr 0x300 with mem_ack held low, TIMEOUT=4 -> mem_req high 4 cycles, then DONE with ReadData=0 and BusErrM=1 for 1 cycle, then IDLE.
REQ-038 Reset=0 on the second BUSY cycle of an LW -> mem_req=0 next cycle, FSM in IDLE, StallM=0. A later mem_ack=1 SHALL produce no DONE cycle and no ReadData change.
